// File: rtl/bf_input_port_if.sv
// CPU-side byte request/acknowledge bundle for the UART input port.
// The master raises in_req; the slave answers with a one-cycle in_ack.
interface bf_input_port_if;
  logic       in_req;
  logic       in_ack;
  logic [7:0] in_data;

  modport master (
    output in_req,
    input  in_ack,
    input  in_data
  );

  modport slave (
    input  in_req,
    output in_ack,
    output in_data
  );
endinterface

// File: rtl/bf_input_port.sv
// UART receiver feeding a byte FIFO that the CPU drains with a
// level request / pulse acknowledge handshake.
module bf_input_port #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        rx,
  bf_input_port_if.slave              cpu,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  output logic                        frame_err,
  input  logic                        clear_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] FULL_LD =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] DEPTH_C =
    (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  logic      sync1, sync2;
  logic      rxs;
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    sh, sh_n;
  logic          push, ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, wr, pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rxs = sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RX_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      sh    <= sh_n;
    end
  end

  // cnt counts down to the next sample point; reloaded on each move
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitn_n   = bitn;
    sh_n     = sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      RX_IDLE: begin
        bitn_n = '0;
        if (!rxs) begin
          state_n = RX_START;
          cnt_n   = HALF_LD;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (!rxs) begin
            state_n = RX_DATA;
            cnt_n   = FULL_LD;
          end else begin
            state_n = RX_IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          sh_n   = {rxs, sh[7:1]};
          cnt_n  = FULL_LD;
          bitn_n = bitn + 3'd1;
          if (bitn == 3'd7) begin
            state_n = RX_STOP;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          cnt_n = '0;
          if (rxs) begin
            push    = 1'b1;
            state_n = RX_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = RX_BREAK;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RX_BREAK: begin
        if (rxs) begin
          state_n = RX_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = RX_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign full = (fifo_count == DEPTH_C);
  assign wr   = push && !full;
  assign pop  = cpu.in_req && !cpu.in_ack &&
                (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= sh;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr        <= '0;
      rptr        <= '0;
      fifo_count  <= '0;
      cpu.in_ack  <= 1'b0;
      cpu.in_data <= 8'h00;
    end else begin
      cpu.in_ack <= pop;
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr        <= rptr + 1'b1;
        cpu.in_data <= mem[rptr];
      end
      if (wr && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !wr) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (clear_err) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err <= 1'b1;
      end
      if (push && full) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bf_input_port.sv
// Self-checking bench for bf_input_port against a queue-based
// model of the receive FIFO and sticky error flags.
module tb_bf_input_port;
  localparam int CPB   = 104;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       clear_err = 1'b0;
  logic [4:0] fifo_count;
  logic       overrun, frame_err;

  bf_input_port_if bus();

  bf_input_port #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx(rx),
    .cpu(bus.slave),
    .fifo_count(fifo_count),
    .overrun(overrun),
    .frame_err(frame_err),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = 1'b1;
    cycles(CPB);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic do_pop(output bit got, output logic [7:0] d,
                        output logic ack2);
    got = 1'b0;
    d = 8'h00;
    bus.in_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ack === 1'b1) begin
        got = 1'b1;
        d = bus.in_data;
        break;
      end
    end
    bus.in_req = 1'b0;
    @(negedge clk);
    ack2 = bus.in_ack;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    cycles(3);
    total++;
    if (bus.in_ack !== 1'b0) begin
      bad++; $display("FAIL rst_ack got=%b exp=0", bus.in_ack);
    end
    total++;
    if (bus.in_data !== 8'h00) begin
      bad++; $display("FAIL rst_data got=%h exp=00", bus.in_data);
    end
    total++;
    if (fifo_count !== 5'd0) begin
      bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count);
    end
    total++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%b%b exp=00",
                      overrun, frame_err);
    end
    resetn = 1'b1;
    cycles(5);
  endtask

  task automatic test_single;
    bit got; logic [7:0] d; logic a2; logic [7:0] e;
    send_byte(8'h41);
    total++;
    if (fifo_count !== 5'(q.size())) begin
      bad++; $display("FAIL single_count got=%0d exp=%0d",
                      fifo_count, q.size());
    end
    do_pop(got, d, a2);
    e = q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("FAIL single_ack got=timeout exp=pulse");
    end
    total++;
    if (d !== e) begin
      bad++; $display("FAIL single_data got=%h exp=%h", d, e);
    end
    total++;
    if (a2 !== 1'b0) begin
      bad++; $display("FAIL single_pulse got=%b exp=0", a2);
    end
    total++;
    if (fifo_count !== 5'd0) begin
      bad++; $display("FAIL single_empty got=%0d exp=0", fifo_count);
    end
  endtask

  task automatic test_random;
    bit got; logic [7:0] d; logic a2; logic [7:0] e;
    int n;
    n = $urandom_range(3, 7);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    total++;
    if (fifo_count !== 5'(q.size())) begin
      bad++; $display("FAIL rand_count got=%0d exp=%0d",
                      fifo_count, q.size());
    end
    for (int i = 0; i < n; i++) begin
      do_pop(got, d, a2);
      e = q.pop_front();
      total++;
      if (!got || d !== e || a2 !== 1'b0) begin
        bad++; $display("FAIL rand_pop%0d got=%h/%b/%b exp=%h/1/0",
                        i, d, got, a2, e);
      end
    end
  endtask

  task automatic test_overrun;
    bit got; logic [7:0] d; logic a2; logic [7:0] e;
    for (int b = 0; b <= 16; b++) send_byte(8'(b));
    total++;
    if (fifo_count !== 5'(q.size())) begin
      bad++; $display("FAIL ovr_count got=%0d exp=%0d",
                      fifo_count, q.size());
    end
    total++;
    if (overrun !== m_ovr) begin
      bad++; $display("FAIL ovr_flag got=%b exp=%b", overrun, m_ovr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(got, d, a2);
      e = q.pop_front();
      total++;
      if (!got || d !== e) begin
        bad++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, d, e);
      end
    end
    total++;
    if (fifo_count !== 5'd0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL ovr_drain got=%0d/%b exp=0/0",
                      fifo_count, frame_err);
    end
    clear_err = 1'b1;
    cycles(1);
    clear_err = 1'b0;
    m_ovr = 1'b0;
    cycles(1);
    total++;
    if (overrun !== m_ovr) begin
      bad++; $display("FAIL ovr_clear got=%b exp=%b", overrun, m_ovr);
    end
  endtask

  task automatic test_back_to_back;
    int last, n;
    logic [7:0] e;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    last = -1;
    n = 0;
    bus.in_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.in_ack === 1'b1) begin
        if (n > 0) begin
          total++;
          if (i - last != 2) begin
            bad++; $display("FAIL b2b_gap got=%0d exp=2", i - last);
          end
        end
        e = (q.size() > 0) ? q.pop_front() : 8'h00;
        total++;
        if (bus.in_data !== e) begin
          bad++; $display("FAIL b2b_data got=%h exp=%h",
                          bus.in_data, e);
        end
        last = i;
        n++;
      end
    end
    bus.in_req = 1'b0;
    total++;
    if (n != 3) begin
      bad++; $display("FAIL b2b_acks got=%0d exp=3", n);
    end
  endtask

  task automatic test_break;
    bit got; logic [7:0] d; logic a2; logic [7:0] e;
    rx = 1'b0;
    cycles(12 * CPB);
    rx = 1'b1;
    m_ferr = 1'b1;
    cycles(2 * CPB);
    total++;
    if (frame_err !== m_ferr) begin
      bad++; $display("FAIL brk_ferr got=%b exp=%b", frame_err, m_ferr);
    end
    total++;
    if (fifo_count !== 5'(q.size()) || overrun !== m_ovr) begin
      bad++; $display("FAIL brk_state got=%0d/%b exp=%0d/%b",
                      fifo_count, overrun, q.size(), m_ovr);
    end
    send_byte(8'h55);
    do_pop(got, d, a2);
    e = q.pop_front();
    total++;
    if (!got || d !== e) begin
      bad++; $display("FAIL brk_rx got=%h exp=%h", d, e);
    end
    clear_err = 1'b1;
    cycles(1);
    clear_err = 1'b0;
    m_ferr = 1'b0;
    cycles(1);
    total++;
    if (frame_err !== m_ferr) begin
      bad++; $display("FAIL brk_clear got=%b exp=%b", frame_err, m_ferr);
    end
  endtask

  task automatic test_glitch;
    bit got; logic [7:0] d; logic a2; logic [7:0] e;
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(3 * CPB);
    total++;
    if (fifo_count !== 5'd0 || overrun !== 1'b0 ||
        frame_err !== 1'b0) begin
      bad++; $display("FAIL glitch got=%0d/%b/%b exp=0/0/0",
                      fifo_count, overrun, frame_err);
    end
    send_byte(8'($urandom));
    do_pop(got, d, a2);
    e = q.pop_front();
    total++;
    if (!got || d !== e) begin
      bad++; $display("FAIL glitch_rx got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_empty_req;
    int acks, push_at, ack_at;
    logic [7:0] d, e;
    acks = 0;
    bus.in_req = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.in_ack === 1'b1) acks++;
    end
    total++;
    if (acks != 0 || fifo_count !== 5'd0) begin
      bad++; $display("FAIL empty_req got=%0d/%0d exp=0/0",
                      acks, fifo_count);
    end
    push_at = -1;
    ack_at = -1;
    d = 8'h00;
    fork
      send_byte(8'h7E);
      begin
        for (int i = 0; i < 11 * CPB; i++) begin
          @(negedge clk);
          if (push_at < 0 && fifo_count === 5'd1) push_at = i;
          if (bus.in_ack === 1'b1) begin
            if (ack_at < 0) begin
              ack_at = i;
              d = bus.in_data;
            end
            acks++;
          end
        end
      end
    join
    bus.in_req = 1'b0;
    e = q.pop_front();
    total++;
    if (push_at < 0 || ack_at != push_at + 1) begin
      bad++; $display("FAIL empty_lat got=%0d exp=%0d",
                      ack_at, push_at + 1);
    end
    total++;
    if (d !== e || acks != 1) begin
      bad++; $display("FAIL empty_data got=%h/%0d exp=%h/1",
                      d, acks, e);
    end
  endtask

  task automatic test_reset_midframe;
    bit got; logic [7:0] d; logic a2; logic [7:0] e;
    send_byte(8'($urandom));
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(i);
      cycles(CPB);
    end
    rx = 1'b0;
    cycles(CPB / 2);
    resetn = 1'b0;
    cycles(2);
    q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    total++;
    if (bus.in_ack !== 1'b0 || bus.in_data !== 8'h00 ||
        fifo_count !== 5'd0 || overrun !== m_ovr ||
        frame_err !== m_ferr) begin
      bad++; $display("FAIL mid_rst got=%b/%h/%0d/%b/%b exp=0/00/0/0/0",
                      bus.in_ack, bus.in_data, fifo_count,
                      overrun, frame_err);
    end
    rx = 1'b1;
    resetn = 1'b1;
    cycles(2 * CPB);
    send_byte(8'hA5);
    total++;
    if (fifo_count !== 5'(q.size())) begin
      bad++; $display("FAIL mid_count got=%0d exp=%0d",
                      fifo_count, q.size());
    end
    do_pop(got, d, a2);
    e = q.pop_front();
    total++;
    if (!got || d !== e) begin
      bad++; $display("FAIL mid_rx got=%h exp=%h", d, e);
    end
  endtask

  initial begin
    bus.in_req = 1'b0;
    test_reset();
    test_single();
    test_random();
    test_overrun();
    test_back_to_back();
    test_break();
    test_glitch();
    test_empty_req();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
